// File: rtl/reg_bank_wr_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM state encodings
// and default bank geometry.
`timescale 1ns/1ps
package reg_bank_wr_arbiter_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREG_DEF  = 4;
  localparam int AW_DEF    = 2;

  // 2'd3 is unreachable in normal operation and is recovered to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_ACK     = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

endpackage

// File: rtl/reg_bank_wr_arbiter_rr_arb2.sv
// Combinational two-input round-robin picker: a lone request wins outright,
// a tie goes to the requester named by prio.
`timescale 1ns/1ps
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 & req1) ? prio : req1;
  end

endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Two-requester four-phase write sequencer for a bank of NREG registers.
// One grant at a time: IDLE -> WRITE (one-cycle enable) -> ACK (hold until req drops).
`timescale 1ns/1ps
module reg_bank_wr_arbiter
  import reg_bank_wr_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic [NREG-1:0]  reg_en,
  output logic [WIDTH-1:0] reg_d,
  output logic             busy,
  output logic             prio
);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [NREG-1:0]  reg_en_q, reg_en_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             busy_q, busy_d;
  logic             prio_q, prio_d;

  logic             gnt_valid;
  logic             gnt_id;
  logic [AW-1:0]    addr_sel;
  logic [WIDTH-1:0] data_sel;
  logic [NREG-1:0]  addr_dec;
  logic             req_g;

  rr_arb2 u_rr_arb2 (
    .req0      (req0),
    .req1      (req1),
    .prio      (prio_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign addr_sel = gnt_id ? addr1 : addr0;
  assign data_sel = gnt_id ? data1 : data0;
  assign req_g    = grant_q ? req1 : req0;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
    assign addr_dec[gi] = (addr_sel == AW'(gi));
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    prio_d   = prio_q;
    reg_en_d = '0;
    reg_d_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d  = ST_WRITE;
          grant_d  = gnt_id;
          reg_en_d = addr_dec;
          reg_d_d  = data_sel;
        end
      end
      ST_WRITE: begin
        // The bank captures on this edge; the enable drops by default.
        state_d = ST_ACK;
        if (grant_q) ack1_d = 1'b1;
        else         ack0_d = 1'b1;
      end
      ST_ACK: begin
        if (!req_g) begin
          state_d = ST_IDLE;
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          prio_d  = ~grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      reg_en_q <= '0;
      reg_d_q  <= '0;
      busy_q   <= 1'b0;
      prio_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
      busy_q   <= busy_d;
      prio_q   <= prio_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign busy   = busy_q;
  assign prio   = prio_q;

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed bench for reg_bank_wr_arbiter with a behavioural bank model
// written whenever reg_en has a bit set.
`timescale 1ns/1ps
module tb_reg_bank_wr_arbiter;

  logic       clk;
  logic       reset_n;
  logic       req0, req1;
  logic [1:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;
  logic [3:0] reg_en;
  logic [7:0] reg_d;
  logic       busy;
  logic       prio;

  logic [7:0] bank [4];
  int tests_run;
  int tests_failed;

  reg_bank_wr_arbiter #(.WIDTH(8), .NREG(4), .AW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .addr0   (addr0),
    .data0   (data0),
    .ack0    (ack0),
    .req1    (req1),
    .addr1   (addr1),
    .data1   (data1),
    .ack1    (ack1),
    .reg_en  (reg_en),
    .reg_d   (reg_d),
    .busy    (busy),
    .prio    (prio)
  );

  initial clk = 1'b0;
  always #7.5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (reg_en[i]) bank[i] <= reg_d;
  end

  // Continuous invariants: acks exclusive, enable at most one-hot.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ack0 && ack1) begin
        tests_failed++;
        $display("FAIL ack_exclusive: ack0=%b ack1=%b required not both 1", ack0, ack1);
      end
      if ($countones(reg_en) > 1) begin
        tests_failed++;
        $display("FAIL reg_en_onehot: reg_en=%b required at most one bit", reg_en);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'hEE;
    req1 = 1'b0; addr1 = 2'd0; data1 = 8'h00;
    for (int i = 0; i < 4; i++) bank[i] = 8'h00;
    #20;
    tests_run++;
    if ({ack0, ack1, busy, prio} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ack0/ack1/busy/prio=%b required 0000", {ack0, ack1, busy, prio});
    end
    tests_run++;
    if ({reg_en, reg_d} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_data: reg_en=%b reg_d=%h required 0000/00", reg_en, reg_d);
    end
    tests_run++;
    if (bank[1] !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_no_write: bank1=%h required 00", bank[1]);
    end
    req0 = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    tests_run++;
    if ({busy, reg_en} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b reg_en=%b required 0/0000", busy, reg_en);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_write();
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
    tick();
    tests_run++;
    if (reg_en !== 4'b0100 || reg_d !== 8'hA5 || ack0 !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_write_en: reg_en=%b reg_d=%h ack0=%b busy=%b required 0100/a5/0/1",
               reg_en, reg_d, ack0, busy);
    end
    addr0 = 2'd0; data0 = 8'h00;
    tick();
    tests_run++;
    if (reg_en !== 4'b0000 || ack0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_write_ack: reg_en=%b ack0=%b required 0000/1", reg_en, ack0);
    end
    tests_run++;
    if (bank[2] !== 8'hA5 || bank[0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_write_bank: bank2=%h bank0=%h required a5/00", bank[2], bank[0]);
    end
    tick();
    tests_run++;
    if (ack0 !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_write_hold: ack0=%b busy=%b required 1/1", ack0, busy);
    end
    req0 = 1'b0;
    tick();
    tests_run++;
    if (ack0 !== 1'b0 || busy !== 1'b0 || prio !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_write_release: ack0=%b busy=%b prio=%b required 0/0/1", ack0, busy, prio);
    end
    $display("[TB] test_single_write done");
  endtask

  task automatic test_tie();
    do_reset();
    req0 = 1'b1; addr0 = 2'd0; data0 = 8'h11;
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h33;
    tick();
    tests_run++;
    if (reg_en !== 4'b0001 || reg_d !== 8'h11) begin
      tests_failed++;
      $display("FAIL tie_first: reg_en=%b reg_d=%h required 0001/11", reg_en, reg_d);
    end
    tick();
    tests_run++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_ack0: ack0=%b ack1=%b required 1/0", ack0, ack1);
    end
    req0 = 1'b0;
    tick();
    tests_run++;
    if (ack0 !== 1'b0 || prio !== 1'b1 || reg_en !== 4'b0000) begin
      tests_failed++;
      $display("FAIL tie_turn: ack0=%b prio=%b reg_en=%b required 0/1/0000", ack0, prio, reg_en);
    end
    tick();
    tests_run++;
    if (reg_en !== 4'b1000 || reg_d !== 8'h33) begin
      tests_failed++;
      $display("FAIL tie_second: reg_en=%b reg_d=%h required 1000/33", reg_en, reg_d);
    end
    tick();
    tests_run++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_ack1: ack0=%b ack1=%b required 0/1", ack0, ack1);
    end
    req1 = 1'b0;
    tick();
    tests_run++;
    if (bank[0] !== 8'h11 || bank[3] !== 8'h33 || prio !== 1'b0 || ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_final: bank0=%h bank3=%h prio=%b ack1=%b required 11/33/0/0",
               bank[0], bank[3], prio, ack1);
    end
    $display("[TB] test_tie done");
  endtask

  task automatic test_fairness();
    int  g_cnt;
    int  order [6];
    bit  seen0, seen1, prev0, prev1, done;
    int  iss0, iss1;
    g_cnt = 0; seen0 = 0; seen1 = 0; prev0 = 0; prev1 = 0; iss0 = 0; iss1 = 0; done = 0;
    for (int i = 0; i < 6; i++) order[i] = -1;
    addr0 = 2'd1; data0 = 8'h44; addr1 = 2'd2; data1 = 8'h77;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (ack0 && !prev0) begin
        if (g_cnt < 6) order[g_cnt] = 0;
        g_cnt++;
      end
      if (ack1 && !prev1) begin
        if (g_cnt < 6) order[g_cnt] = 1;
        g_cnt++;
      end
      prev0 = ack0; prev1 = ack1;
      if (ack0) begin
        if (seen0) req0 = 1'b0;
        seen0 = 1'b1;
      end else begin
        seen0 = 1'b0;
        if (!req0 && iss0 < 3) begin req0 = 1'b1; iss0++; end
      end
      if (ack1) begin
        if (seen1) req1 = 1'b0;
        seen1 = 1'b1;
      end else begin
        seen1 = 1'b0;
        if (!req1 && iss1 < 3) begin req1 = 1'b1; iss1++; end
      end
      if (iss0 == 3 && iss1 == 3 && !req0 && !req1 && !ack0 && !ack1) begin
        done = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!done || g_cnt != 6) begin
      tests_failed++;
      $display("FAIL fair_count: done=%0d grants=%0d required done=1 grants=6", done, g_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (order[i] != (i % 2)) begin
        tests_failed++;
        $display("FAIL fair_order[%0d]: grant=%0d required %0d", i, order[i], i % 2);
      end
    end
    tests_run++;
    if (prio !== 1'b0 || bank[1] !== 8'h44 || bank[2] !== 8'h77) begin
      tests_failed++;
      $display("FAIL fair_end: prio=%b bank1=%h bank2=%h required 0/44/77", prio, bank[1], bank[2]);
    end
    $display("[TB] test_fairness done");
  endtask

  task automatic test_reset_mid_write();
    req0 = 1'b1; addr0 = 2'd3; data0 = 8'hC3;
    @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (reg_en !== 4'b0000 || busy !== 1'b0 || ack0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_cancel: reg_en=%b busy=%b ack0=%b required 0000/0/0", reg_en, busy, ack0);
    end
    tick();
    tests_run++;
    if (bank[3] !== 8'h33) begin
      tests_failed++;
      $display("FAIL midreset_keep: bank3=%h required 33", bank[3]);
    end
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (reg_en !== 4'b1000 || reg_d !== 8'hC3 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_restart: reg_en=%b reg_d=%h busy=%b required 1000/c3/1", reg_en, reg_d, busy);
    end
    tick();
    tests_run++;
    if (ack0 !== 1'b1 || bank[3] !== 8'hC3) begin
      tests_failed++;
      $display("FAIL midreset_complete: ack0=%b bank3=%h required 1/c3", ack0, bank[3]);
    end
    req0 = 1'b0;
    tick();
    tests_run++;
    if (ack0 !== 1'b0 || prio !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_release: ack0=%b prio=%b required 0/1", ack0, prio);
    end
    $display("[TB] test_reset_mid_write done");
  endtask

  task automatic test_early_drop();
    req1 = 1'b1; addr1 = 2'd1; data1 = 8'h5A;
    tick();
    tests_run++;
    if (reg_en !== 4'b0010 || reg_d !== 8'h5A) begin
      tests_failed++;
      $display("FAIL early_en: reg_en=%b reg_d=%h required 0010/5a", reg_en, reg_d);
    end
    req1 = 1'b0;
    tick();
    tests_run++;
    if (ack1 !== 1'b1 || bank[1] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL early_ack: ack1=%b bank1=%h required 1/5a", ack1, bank[1]);
    end
    tick();
    tests_run++;
    if (ack1 !== 1'b0 || busy !== 1'b0 || prio !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_pulse: ack1=%b busy=%b prio=%b required 0/0/0", ack1, busy, prio);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || reg_en !== 4'b0000 || ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_idle: busy=%b reg_en=%b ack1=%b required 0/0000/0", busy, reg_en, ack1);
    end
    $display("[TB] test_early_drop done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single_write();
    test_tie();
    test_fairness();
    test_reset_mid_write();
    test_early_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
